ray_dir_issuer: RTL

//  Transmit side of the inverted-direction pipe. Accepts raw XYZ ray directions via valid/ready
//  and stamps each with a sequential tag. Drives start + TaggedDirection into inverted_direction.
//  The issuer is the only source of backpressure: it caps outstanding requests so the TD FIFO

---
 rtl/ray_dir_issuer_pkg.sv | 38 +++
 rtl/ray_dir_issuer_credit_counter.sv | 40 ++++
 rtl/ray_dir_issuer.sv | 115 +++++++++++
 3 files changed

// File: rtl/ray_dir_issuer_pkg.sv
// Shared types for the ray direction issuer: tagged direction word, FSM states,
// component/tag widths (WIDTH, Q_BITS, TAG_SIZE macros) and the tag increment helper.
`ifndef WIDTH
`define WIDTH 16
`endif
`ifndef Q_BITS
`define Q_BITS 8
`endif
`ifndef TAG_SIZE
`define TAG_SIZE 5
`endif

package ray_dir_issuer_pkg;

    localparam int WIDTH        = `WIDTH;
    localparam int TAG_SIZE     = `TAG_SIZE;
    localparam int MAX_INFLIGHT = 24;
    localparam int CNT_W        = $clog2(MAX_INFLIGHT + 1);

    typedef struct packed {
        logic [TAG_SIZE-1:0] tag;
        logic [WIDTH-1:0]    x;
        logic [WIDTH-1:0]    y;
        logic [WIDTH-1:0]    z;
    } TaggedDirection;

    typedef enum logic [1:0] {
        ACTIVE,
        DRAIN,
        DONE
    } issuer_state_t;

    // Tags wrap naturally at 2**TAG_SIZE because the sum is truncated to TAG_SIZE bits.
    function automatic logic [TAG_SIZE-1:0] tag_inc(input logic [TAG_SIZE-1:0] t);
        return t + 1'b1;
    endfunction

endpackage

// File: rtl/ray_dir_issuer_credit_counter.sv
// Outstanding-request counter for the issuer: +1 on issue, -1 on return,
// unchanged when both happen together, never drops below zero.
// has_credit looks at the value the count will hold after this cycle, so the
// issuer can register its ready flag without a combinational path from valid.
module ray_dir_issuer_credit_counter
    import ray_dir_issuer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             has_credit
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

    logic [CNT_W-1:0] count_next;

    // Next count: a lone return at zero is a stray result and leaves the count at zero.
    always_comb begin
        count_next = count;
        if (inc && !dec && count != MAX_CNT) begin
            count_next = count + 1'b1;
        end else if (dec && !inc && count != '0) begin
            count_next = count - 1'b1;
        end
        has_credit = (count_next < MAX_CNT);
    end

    // Hold the outstanding count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/ray_dir_issuer.sv
// Transmit side of the inverted-direction pipe: stamps incoming directions with
// sequential tags, issues them as one-cycle start pulses, caps outstanding work at
// MAX_INFLIGHT, forwards in-order results and supports a drain/flush handshake.
// Optional macro RAY_ISSUER_TAG_CHECK_EN adds a sticky tag/credit error checker.
module ray_dir_issuer
    import ray_dir_issuer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             dir_valid_in,
    output logic             dir_ready_out,
    input  logic [WIDTH-1:0] dir_x_in,
    input  logic [WIDTH-1:0] dir_y_in,
    input  logic [WIDTH-1:0] dir_z_in,
    input  logic             flush_in,
    output logic             start_out,
    output TaggedDirection   direction_out,
    input  logic             inv_valid_in,
    input  TaggedDirection   inv_dir_in,
    output logic             res_valid_out,
    output TaggedDirection   res_dir_out,
    output logic [CNT_W-1:0] inflight_out,
    output logic             flush_done_out,
    output logic             tag_error_out
);

    issuer_state_t       state;
    issuer_state_t       state_next;
    logic [TAG_SIZE-1:0] next_tag;
    logic                has_credit;
    logic                accept;

    assign accept = dir_valid_in & dir_ready_out;

    ray_dir_issuer_credit_counter u_credit (
        .clk        (clk),
        .reset      (reset),
        .inc        (accept),
        .dec        (inv_valid_in),
        .count      (inflight_out),
        .has_credit (has_credit)
    );

    // Flush sequencing: drain waits for the registered count to reach zero, DONE lasts one cycle.
    always_comb begin
        state_next = state;
        case (state)
            ACTIVE:  if (flush_in) state_next = DRAIN;
            DRAIN:   if (inflight_out == '0) state_next = DONE;
            DONE:    state_next = ACTIVE;
            default: state_next = ACTIVE;
        endcase
    end

    // FSM state plus registered ready and flush-done, both derived from next-cycle state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ACTIVE;
            dir_ready_out  <= 1'b0;
            flush_done_out <= 1'b0;
        end else begin
            state          <= state_next;
            dir_ready_out  <= (state_next == ACTIVE) && has_credit;
            flush_done_out <= (state_next == DONE);
        end
    end

    // Issue path: tag each accepted direction and pulse start; direction holds between issues.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_out     <= 1'b0;
            direction_out <= '0;
            next_tag      <= '0;
        end else begin
            start_out <= accept;
            if (accept) begin
                direction_out <= {next_tag, dir_x_in, dir_y_in, dir_z_in};
                next_tag      <= tag_inc(next_tag);
            end
        end
    end

    // Return path: results pass through one register stage untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_valid_out <= 1'b0;
            res_dir_out   <= '0;
        end else begin
            res_valid_out <= inv_valid_in;
            if (inv_valid_in) begin
                res_dir_out <= inv_dir_in;
            end
        end
    end

`ifdef RAY_ISSUER_TAG_CHECK_EN
    logic [TAG_SIZE-1:0] exp_tag;

    // Results must come back in issue order; out-of-order tags or stray returns latch an error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_tag       <= '0;
            tag_error_out <= 1'b0;
        end else if (inv_valid_in) begin
            if (inv_dir_in.tag != exp_tag || inflight_out == '0) begin
                tag_error_out <= 1'b1;
            end
            exp_tag <= tag_inc(exp_tag);
        end
    end
`else
    assign tag_error_out = 1'b0;
`endif

endmodule
